airlock_sequencer: RTL and testbench

Top-level sequencer for the interlock chamber. It takes entry and exit requests and drives the inner and outer doors. It issues start pulses to the chamber's pressurizer and depressurizer blocks and monitors their busy outputs. It enforces two rules: both doors are never open together, and no door opens while a pump cycle is running.

---
 rtl/airlock_pkg.sv | 37 +++
 rtl/airlock_if.sv | 45 ++++
 rtl/airlock_watchdog.sv | 44 ++++
 rtl/airlock_sequencer.sv | 131 +++++++++++++
 tb/tb_airlock_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/airlock_pkg.sv
// ---------------------------------------------------------------------------
// airlock_pkg
// Shared definitions for the airlock sequencer:
//   - 4-bit state encoding (P_IDLE = 0, FAULT = 4'hF)
//   - door-direction constants DIR_IN / DIR_OUT
//   - default watchdog limit and counter width
// ---------------------------------------------------------------------------
package airlock_pkg;

    // State encoding, also driven on the debug state output.
    localparam logic [3:0] ST_P_IDLE = 4'h0;
    localparam logic [3:0] ST_P_DOOR = 4'h1;
    localparam logic [3:0] ST_D_KICK = 4'h2;
    localparam logic [3:0] ST_D_WAIT = 4'h3;
    localparam logic [3:0] ST_D_RUN  = 4'h4;
    localparam logic [3:0] ST_V_IDLE = 4'h5;
    localparam logic [3:0] ST_V_DOOR = 4'h6;
    localparam logic [3:0] ST_P_KICK = 4'h7;
    localparam logic [3:0] ST_P_WAIT = 4'h8;
    localparam logic [3:0] ST_P_RUN  = 4'h9;
    localparam logic [3:0] ST_FAULT  = 4'hF;

    // Direction of the transit in progress.
    localparam logic DIR_OUT = 1'b0;
    localparam logic DIR_IN  = 1'b1;

    // Pump cycle is 2880 clocks; the default leaves roughly 6% margin.
    localparam int WD_CYCLES_DEFAULT = 3072;
    localparam int WD_W_DEFAULT      = 12;

    // True in the states where a pump cycle is being started or is running.
    function automatic logic is_pump_state(input logic [3:0] st);
        return (st == ST_D_KICK) || (st == ST_D_WAIT) || (st == ST_D_RUN) ||
               (st == ST_P_KICK) || (st == ST_P_WAIT) || (st == ST_P_RUN);
    endfunction

endpackage

// File: rtl/airlock_if.sv
// ---------------------------------------------------------------------------
// airlock_if
// Signal bundle between the airlock sequencer and the chamber hardware.
//   Requests / status into the sequencer:
//     enter_req, exit_req  - level requests, held by the requester until served
//     occupant_clear       - doorway clear, lets the open door close
//     press_busy           - pressurizer running
//     depress_busy         - depressurizer running
//   Commands / status out of the sequencer:
//     press_start, depress_start - one-cycle start pulses to the pumps
//     inner_door_open, outer_door_open - door commands
//     pressurized          - chamber at station pressure
//     fault                - watchdog trip
//     state                - current FSM state, for debug
// Handshake: there is no valid/ready pair. Requests are levels sampled only
// in the two idle states; a start pulse is answered by the pump raising busy
// a few cycles later and dropping it when the cycle completes.
// Modports: master = sequencer side, slave = chamber/environment side.
// ---------------------------------------------------------------------------
interface airlock_if;
    logic       enter_req;
    logic       exit_req;
    logic       occupant_clear;
    logic       press_busy;
    logic       depress_busy;
    logic       press_start;
    logic       depress_start;
    logic       inner_door_open;
    logic       outer_door_open;
    logic       pressurized;
    logic       fault;
    logic [3:0] state;

    modport master (
        input  enter_req, exit_req, occupant_clear, press_busy, depress_busy,
        output press_start, depress_start, inner_door_open, outer_door_open,
               pressurized, fault, state
    );

    modport slave (
        output enter_req, exit_req, occupant_clear, press_busy, depress_busy,
        input  press_start, depress_start, inner_door_open, outer_door_open,
               pressurized, fault, state
    );
endinterface

// File: rtl/airlock_watchdog.sv
// ---------------------------------------------------------------------------
// airlock_watchdog
// Saturating cycle counter bounding one pump cycle.
//   clock, reset - system clock, synchronous active-high reset
//   clear        - restart the count at zero (takes priority)
//   enable       - count this cycle
//   expired      - count has reached WD_CYCLES-1
// The count stops at WD_CYCLES-1 so it never wraps back to a "safe" value.
// ---------------------------------------------------------------------------
module airlock_watchdog #(
    parameter int WD_CYCLES = 3072,
    parameter int WD_W      = 12
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [WD_W-1:0] LIMIT = WD_W'(WD_CYCLES - 1);

    logic [WD_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + WD_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/airlock_sequencer.sv
// ---------------------------------------------------------------------------
// airlock_sequencer
// Moore FSM sequencing the inner/outer doors and the two pumps of the
// interlock chamber. Guarantees both doors are never open together and that
// no door opens while a pump cycle is in progress.
//   clock - system clock
//   reset - synchronous, active-high; returns to P_IDLE with dir=OUT
//   bus   - airlock_if.master (requests, pump busy in; starts, doors,
//           pressurized, fault, debug state out)
// Optional feature: define AIRLOCK_WATCHDOG_EN to bound each pump cycle by
// WD_CYCLES clocks and enter FAULT (held until reset) when it overruns.
// Without it, fault is 0 and the WAIT/RUN states wait indefinitely.
// ---------------------------------------------------------------------------
module airlock_sequencer
    import airlock_pkg::*;
#(
    parameter int WD_CYCLES = WD_CYCLES_DEFAULT,
    parameter int WD_W      = WD_W_DEFAULT
) (
    input  logic     clock,
    input  logic     reset,
    airlock_if.master bus
);

    if ((WD_CYCLES < 2) || (WD_CYCLES > (1 << WD_W))) begin : g_bad_wd_cfg
        $error("airlock_sequencer: WD_CYCLES must lie in 2 .. 2**WD_W");
    end

    logic [3:0] state_q, state_d;
    logic       dir_q, dir_d;
    logic       wd_expired;

`ifdef AIRLOCK_WATCHDOG_EN
    logic wd_clear;
    logic wd_enable;

    // KICK lasts one cycle, so clearing whenever KICK is next is a clear on entry.
    assign wd_clear  = (state_d == ST_D_KICK) || (state_d == ST_P_KICK);
    assign wd_enable = is_pump_state(state_q);

    airlock_watchdog #(
        .WD_CYCLES (WD_CYCLES),
        .WD_W      (WD_W)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        case (state_q)
            // Exit wins when both requests are raised at pressure.
            ST_P_IDLE: begin
                if (bus.exit_req) begin
                    state_d = ST_P_DOOR;
                    dir_d   = DIR_OUT;
                end else if (bus.enter_req) begin
                    state_d = ST_D_KICK;
                    dir_d   = DIR_IN;
                end
            end
            ST_P_DOOR: begin
                if (bus.occupant_clear) begin
                    state_d = (dir_q == DIR_OUT) ? ST_D_KICK : ST_P_IDLE;
                end
            end
            ST_D_KICK: state_d = ST_D_WAIT;
            ST_D_WAIT: begin
                if (wd_expired)             state_d = ST_FAULT;
                else if (bus.depress_busy)  state_d = ST_D_RUN;
            end
            ST_D_RUN: begin
                if (wd_expired)             state_d = ST_FAULT;
                else if (!bus.depress_busy) state_d = ST_V_DOOR;
            end
            // Enter wins when both requests are raised at vacuum.
            ST_V_IDLE: begin
                if (bus.enter_req) begin
                    state_d = ST_V_DOOR;
                    dir_d   = DIR_IN;
                end else if (bus.exit_req) begin
                    state_d = ST_P_KICK;
                    dir_d   = DIR_OUT;
                end
            end
            ST_V_DOOR: begin
                if (bus.occupant_clear) begin
                    state_d = (dir_q == DIR_IN) ? ST_P_KICK : ST_V_IDLE;
                end
            end
            ST_P_KICK: state_d = ST_P_WAIT;
            ST_P_WAIT: begin
                if (wd_expired)             state_d = ST_FAULT;
                else if (bus.press_busy)    state_d = ST_P_RUN;
            end
            ST_P_RUN: begin
                if (wd_expired)             state_d = ST_FAULT;
                else if (!bus.press_busy)   state_d = ST_P_DOOR;
            end
            ST_FAULT:  state_d = ST_FAULT;
            default:   state_d = ST_P_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_P_IDLE;
            dir_q   <= DIR_OUT;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
        end
    end

    // Pure state decode: every output is registered-state driven.
    assign bus.press_start     = (state_q == ST_P_KICK);
    assign bus.depress_start   = (state_q == ST_D_KICK);
    assign bus.inner_door_open = (state_q == ST_P_DOOR);
    assign bus.outer_door_open = (state_q == ST_V_DOOR);
    assign bus.pressurized     = (state_q == ST_P_IDLE) || (state_q == ST_P_DOOR);
    assign bus.fault           = (state_q == ST_FAULT);
    assign bus.state           = state_q;

endmodule

// File: tb/tb_airlock_sequencer.sv
// ---------------------------------------------------------------------------
// tb_airlock_sequencer
// Bench for airlock_sequencer: vector table with an expected-output queue,
// pump-model sequences for exit/entry, random invariant run, watchdog and
// mid-cycle reset sequences.
// Packed observation: {state[3:0], press_start, depress_start,
//                      inner_door_open, outer_door_open, pressurized, fault}
// ---------------------------------------------------------------------------
module tb_airlock_sequencer;

    localparam logic [9:0] E_PIDLE = {4'h0, 6'b000010};
    localparam logic [9:0] E_PDOOR = {4'h1, 6'b001010};
    localparam logic [9:0] E_DKICK = {4'h2, 6'b010000};
    localparam logic [9:0] E_DWAIT = {4'h3, 6'b000000};
    localparam logic [9:0] E_DRUN  = {4'h4, 6'b000000};
    localparam logic [9:0] E_VIDLE = {4'h5, 6'b000000};
    localparam logic [9:0] E_VDOOR = {4'h6, 6'b000100};
    localparam logic [9:0] E_PKICK = {4'h7, 6'b100000};
    localparam logic [9:0] E_PWAIT = {4'h8, 6'b000000};
    localparam logic [9:0] E_PRUN  = {4'h9, 6'b000000};
    localparam logic [9:0] E_FAULT = {4'hF, 6'b000001};

    typedef struct {
        logic       en;
        logic       ex;
        logic       clr;
        logic       pb;
        logic       db;
        logic [9:0] exp;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clock;
    logic reset;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    airlock_if bus ();

    airlock_sequencer #(
        .WD_CYCLES (64),
        .WD_W      (12)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- busy sources ----------------
    logic pump_mode;
    logic tab_pb, tab_db;
    logic pump_pb, pump_db;
    int   p_cnt, d_cnt;

    assign bus.press_busy   = pump_mode ? pump_pb : tab_pb;
    assign bus.depress_busy = pump_mode ? pump_db : tab_db;

    // Pump model: busy rises 2 cycles after the start pulse, stays 20 cycles.
    always @(negedge clock) begin
        if (!pump_mode) begin
            p_cnt = 0;
            d_cnt = 0;
        end else begin
            if (bus.press_start)       p_cnt = 22;
            else if (p_cnt > 0)        p_cnt = p_cnt - 1;
            if (bus.depress_start)     d_cnt = 22;
            else if (d_cnt > 0)        d_cnt = d_cnt - 1;
        end
        pump_pb = (p_cnt >= 1) && (p_cnt <= 20);
        pump_db = (d_cnt >= 1) && (d_cnt <= 20);
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int passes = 0;
    logic [9:0] exp_q[$];
    logic [3:0] exp_st_q[$];
    logic       mon_en;
    logic [3:0] prev_state;

    function automatic logic [9:0] observe();
        return {bus.state, bus.press_start, bus.depress_start,
                bus.inner_door_open, bus.outer_door_open,
                bus.pressurized, bus.fault};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // State-sequence monitor: pops the next expected state on every change.
    always @(negedge clock) begin
        if (mon_en) begin
            if (bus.state !== prev_state) begin
                if (exp_st_q.size() == 0) check("seq_unexpected", {28'd0, bus.state}, 32'hFF);
                else check("seq_state", {28'd0, bus.state}, {28'd0, exp_st_q.pop_front()});
            end
        end
        prev_state = bus.state;
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic en, input logic ex, input logic clr,
                         input logic pb, input logic db);
        bus.enter_req      = en;
        bus.exit_req       = ex;
        bus.occupant_clear = clr;
        tab_pb             = pb;
        tab_db             = db;
    endtask

    task automatic do_reset();
        @(negedge clock);
        drive(0, 0, 0, 0, 0);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // One table-style cycle: drive at negedge, check just after the next posedge.
    task automatic step(input string name, input logic en, input logic ex,
                        input logic clr, input logic pb, input logic db,
                        input logic [9:0] exp);
        @(negedge clock);
        drive(en, ex, clr, pb, db);
        @(posedge clock);
        #1;
        check(name, {22'd0, observe()}, {22'd0, exp});
    endtask

    // Waits (on negedges) for a state, bounded; the final compare is the check.
    task automatic wait_state(input logic [3:0] st, input int budget, input string name);
        int n = 0;
        while ((bus.state !== st) && (n < budget)) begin
            @(negedge clock);
            n++;
        end
        check(name, {28'd0, bus.state}, {28'd0, st});
    endtask

    vec_t vecs[$];

    initial begin
        pump_mode = 1'b0;
        mon_en    = 1'b0;
        reset     = 1'b1;
        drive(0, 0, 0, 0, 0);

        // Table: requests/clear/busy -> packed outputs after the edge.
        vecs.push_back('{0,0,1,1,1, E_PIDLE}); // clear and busy ignored in idle
        vecs.push_back('{0,1,0,0,0, E_PDOOR}); // exit -> inner door
        vecs.push_back('{1,1,0,0,0, E_PDOOR}); // requests ignored at the door
        vecs.push_back('{0,0,1,0,0, E_DKICK}); // dir=OUT -> depressurize
        vecs.push_back('{0,0,0,0,1, E_DWAIT}); // kick is one cycle
        vecs.push_back('{0,0,0,1,0, E_DWAIT}); // press_busy ignored here
        vecs.push_back('{0,0,1,0,1, E_DRUN });
        vecs.push_back('{1,1,0,0,1, E_DRUN });
        vecs.push_back('{0,0,0,0,0, E_VDOOR}); // busy fell -> outer door
        vecs.push_back('{1,0,0,0,0, E_VDOOR});
        vecs.push_back('{0,0,1,0,0, E_VIDLE}); // dir=OUT -> vacuum idle
        vecs.push_back('{0,0,0,0,0, E_VIDLE});
        vecs.push_back('{1,1,0,0,0, E_VDOOR}); // simultaneous at vacuum: enter wins
        vecs.push_back('{0,0,1,0,0, E_PKICK});
        vecs.push_back('{0,0,0,0,0, E_PWAIT});
        vecs.push_back('{0,0,0,0,1, E_PWAIT}); // depress_busy ignored here
        vecs.push_back('{0,0,0,1,0, E_PRUN });
        vecs.push_back('{0,0,0,1,0, E_PRUN });
        vecs.push_back('{0,0,0,0,0, E_PDOOR});
        vecs.push_back('{0,0,1,0,0, E_PIDLE}); // dir=IN -> done
        vecs.push_back('{1,1,0,0,0, E_PDOOR}); // simultaneous at pressure: exit wins
        vecs.push_back('{0,0,1,0,0, E_DKICK});
        vecs.push_back('{0,0,0,0,0, E_DWAIT});
        vecs.push_back('{0,0,0,0,1, E_DRUN });
        vecs.push_back('{0,0,0,0,0, E_VDOOR});
        vecs.push_back('{0,0,1,0,0, E_VIDLE});
        vecs.push_back('{0,1,0,0,0, E_PKICK}); // exit from vacuum
        vecs.push_back('{0,0,0,0,0, E_PWAIT});
        vecs.push_back('{0,0,0,1,0, E_PRUN });
        vecs.push_back('{0,0,0,0,0, E_PDOOR});
        vecs.push_back('{0,0,1,0,0, E_DKICK}); // dir=OUT continues outward
        vecs.push_back('{0,0,0,0,0, E_DWAIT});
        vecs.push_back('{0,0,0,0,1, E_DRUN });
        vecs.push_back('{0,0,0,0,0, E_VDOOR});
        vecs.push_back('{0,0,1,0,0, E_VIDLE});
        vecs.push_back('{1,0,0,0,0, E_VDOOR}); // enter from vacuum
        vecs.push_back('{0,0,1,0,0, E_PKICK});
        vecs.push_back('{0,0,0,0,0, E_PWAIT});
        vecs.push_back('{0,0,0,1,0, E_PRUN });
        vecs.push_back('{0,0,0,0,0, E_PDOOR});
        vecs.push_back('{0,0,1,0,0, E_PIDLE});
        vecs.push_back('{1,0,0,0,0, E_DKICK}); // enter from pressure

        do_reset();
        @(posedge clock);
        #1;
        check("reset_state", {22'd0, observe()}, {22'd0, E_PIDLE});

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            drive(vecs[i].en, vecs[i].ex, vecs[i].clr, vecs[i].pb, vecs[i].db);
            exp_q.push_back(vecs[i].exp);
            @(posedge clock);
            #1;
            if (exp_q.size() == 0) check($sformatf("vec%0d_empty", i), 1, 0);
            else check($sformatf("vec%0d", i), {22'd0, observe()}, {22'd0, exp_q.pop_front()});
        end

        // Exit with the pump model.
        do_reset();
        pump_mode = 1'b1;
        bus.exit_req = 1'b1;
        @(negedge clock);
        bus.exit_req = 1'b0;
        check("exit_inner_open", {31'd0, bus.inner_door_open}, 1);
        bus.occupant_clear = 1'b1;
        @(negedge clock);
        bus.occupant_clear = 1'b0;
        check("exit_dstart", {31'd0, bus.depress_start}, 1);
        begin
            int n = 1;
            @(negedge clock);
            check("exit_dstart_single", {31'd0, bus.depress_start}, 0);
            while ((bus.state !== 4'h6) && (n < 60)) begin
                @(negedge clock);
                n++;
            end
            check("exit_vdoor_latency", n, 23);
        end
        check("exit_outer_open", {22'd0, observe()}, {22'd0, E_VDOOR});
        bus.occupant_clear = 1'b1;
        @(negedge clock);
        bus.occupant_clear = 1'b0;
        check("exit_vidle", {22'd0, observe()}, {22'd0, E_VIDLE});

        // Entry with the pump model and the state-sequence scoreboard.
        do_reset();
        exp_st_q = '{4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h8, 4'h9, 4'h1, 4'h0};
        prev_state = bus.state;
        mon_en = 1'b1;
        bus.enter_req = 1'b1;
        @(negedge clock);
        bus.enter_req = 1'b0;
        wait_state(4'h6, 60, "entry_wait_vdoor");
        check("entry_outer", {31'd0, bus.outer_door_open}, 1);
        bus.occupant_clear = 1'b1;
        @(negedge clock);
        bus.occupant_clear = 1'b0;
        wait_state(4'h1, 60, "entry_wait_pdoor");
        check("entry_inner", {31'd0, bus.inner_door_open}, 1);
        bus.occupant_clear = 1'b1;
        @(negedge clock);
        bus.occupant_clear = 1'b0;
        check("entry_pidle", {22'd0, observe()}, {22'd0, E_PIDLE});
        @(negedge clock);
        mon_en = 1'b0;
        check("entry_seq_drained", exp_st_q.size(), 0);

        // Random run with safety invariants.
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            @(negedge clock);
            bus.enter_req      = ($urandom_range(0, 3) == 0);
            bus.exit_req       = ($urandom_range(0, 3) == 0);
            bus.occupant_clear = ($urandom_range(0, 2) == 0);
            @(posedge clock);
            #1;
            check("invariant",
                  {29'd0,
                   bus.inner_door_open & bus.outer_door_open,
                   (bus.inner_door_open | bus.outer_door_open) &
                       (bus.press_busy | bus.depress_busy),
                   bus.fault},
                  0);
        end

        // Reset in the middle of a depressurization.
        do_reset();
        bus.exit_req = 1'b1;
        @(negedge clock);
        bus.exit_req = 1'b0;
        bus.occupant_clear = 1'b1;
        @(negedge clock);
        bus.occupant_clear = 1'b0;
        wait_state(4'h4, 20, "rst_wait_drun");
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rst_mid_cycle", {22'd0, observe()}, {22'd0, E_PIDLE});

        // Watchdog: press_busy stuck high in P_RUN.
        do_reset();
        pump_mode = 1'b0;
        step("wd_pdoor", 0,1,0,0,0, E_PDOOR);
        step("wd_dkick", 0,0,1,0,0, E_DKICK);
        step("wd_dwait", 0,0,0,0,0, E_DWAIT);
        step("wd_drun",  0,0,0,0,1, E_DRUN);
        step("wd_vdoor", 0,0,0,0,0, E_VDOOR);
        step("wd_vidle", 0,0,1,0,0, E_VIDLE);
        step("wd_pkick", 0,1,0,0,0, E_PKICK);
        for (int i = 1; i < 63; i++) begin
            @(negedge clock);
            drive(0, 0, 0, 1, 0);
            @(posedge clock);
        end
        step("wd_prun_63", 0,0,0,1,0, E_PRUN);
`ifdef AIRLOCK_WATCHDOG_EN
        step("wd_fault",      0,0,0,1,0, E_FAULT);
        step("wd_fault_hold", 1,1,1,0,0, E_FAULT);
        step("wd_fault_hold2",0,0,0,0,0, E_FAULT);
        do_reset();
        @(posedge clock);
        #1;
        check("wd_reset_clears", {22'd0, observe()}, {22'd0, E_PIDLE});
`else
        step("wd_no_fault",   0,0,0,1,0, E_PRUN);
        step("wd_still_run",  0,0,0,1,0, E_PRUN);
        step("wd_pdoor_late", 0,0,0,0,0, E_PDOOR);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
